// File: rtl/task_responder_fsm.sv
// Responder side of the start/busy/done task handshake. Accepts a one-cycle
// start pulse, runs a fixed WORK_CYCLES-clock job while holding busy, then
// reports a sticky done (normal completion) or a sticky error (aborted job).
// All outputs come straight from flops.
module task_responder_fsm #(
  parameter int WORK_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] progress
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_COMPLETE = 2'b10,
    ST_ERROR    = 2'b11
  } state_e;

  // Parameter sanity: a zero-length job is meaningless, and the counter must
  // be able to hold WORK_CYCLES itself so progress never wraps.
  if (WORK_CYCLES < 1) begin : g_bad_work_cycles
    $error("task_responder_fsm: WORK_CYCLES must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 31 || (WORK_CYCLES >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("task_responder_fsm: CNT_W too narrow for WORK_CYCLES");
  end

  localparam logic [CNT_W-1:0] JOB_LEN = CNT_W'(WORK_CYCLES);

  state_e           state_q,    state_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             error_q,    error_d;
  logic [CNT_W-1:0] progress_q, progress_d;
  logic [CNT_W-1:0] progress_inc;

  assign progress_inc = progress_q + 1'b1;

  // Next-state and next-output decode for the job sequencer.
  always_comb begin
    // NOTE: every signal gets a hold default before the case so that no path
    // leaves one unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    progress_d = progress_q;

    unique case (state_q)
      ST_IDLE, ST_COMPLETE, ST_ERROR: begin
        if (start) begin
          // New job clears the previous outcome; accepted from the
          // one-cycle COMPLETE/ERROR states too so back-to-back requests
          // are never dropped.
          state_d    = ST_RUN;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          progress_d = '0;
        end else begin
          // Outcome flags and progress stay sticky while idle.
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          // Abort takes priority over the final increment; progress frozen.
          state_d = ST_ERROR;
          busy_d  = 1'b0;
          error_d = 1'b1;
          done_d  = 1'b0;
        end else if (progress_inc == JOB_LEN) begin
          state_d    = ST_COMPLETE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          progress_d = progress_inc;
        end else begin
          progress_d = progress_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      progress_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      progress_q <= progress_d;
    end
  end

  assign state    = state_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign progress = progress_q;

endmodule

// File: tb/tb_task_responder_fsm.sv
// Directed bench for task_responder_fsm: a WORK_CYCLES=4 instance exercises
// completion, abort, abort-vs-final-increment, start during RUN/COMPLETE and
// reset mid-job; a WORK_CYCLES=16 instance is driven by a small polling
// master for three back-to-back jobs.
module tb_task_responder_fsm;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_COMP = 2'b10;
  localparam logic [1:0] S_ERR  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, abort_a, start_b, abort_b;
  logic [1:0]  state_a, state_b;
  logic        busy_a, done_a, error_a;
  logic        busy_b, done_b, error_b;
  logic [15:0] progress_a, progress_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  task_responder_fsm #(.WORK_CYCLES(4), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .state(state_a), .busy(busy_a), .done(done_a), .error(error_a),
    .progress(progress_a)
  );

  task_responder_fsm #(.WORK_CYCLES(16), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .state(state_b), .busy(busy_b), .done(done_b), .error(error_b),
    .progress(progress_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs and samples both live 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the full output set of instance A in one call.
  task automatic check_a(input string tag, input logic [1:0] st, input logic bz,
                         input logic dn, input logic er, input logic [15:0] pg);
    check({tag, ".state"},    32'(state_a),    32'(st));
    check({tag, ".busy"},     32'(busy_a),     32'(bz));
    check({tag, ".done"},     32'(done_a),     32'(dn));
    check({tag, ".error"},    32'(error_a),    32'(er));
    check({tag, ".progress"}, 32'(progress_a), 32'(pg));
  endtask

  initial begin
    int k;
    rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_a("reset", S_IDLE, 0, 0, 0, 0);

    // Normal job: busy for 4 cycles, COMPLETE, then IDLE with done sticky.
    start_a = 1'b1; tick(); start_a = 1'b0;
    check_a("t1_start", S_RUN, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_a($sformatf("t1_run%0d", i), S_RUN, 1, 0, 0, 16'(i));
    end
    tick();
    check_a("t1_complete", S_COMP, 0, 1, 0, 4);
    tick();
    check_a("t1_idle", S_IDLE, 0, 1, 0, 4);
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    check_a("abort_in_idle", S_IDLE, 0, 1, 0, 4);

    // Abort in 2nd RUN cycle: ERROR with progress frozen at 1.
    start_a = 1'b1; tick(); start_a = 1'b0;
    check_a("t2_start", S_RUN, 1, 0, 0, 0);
    tick();
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    check_a("t2_error", S_ERR, 0, 0, 1, 1);
    tick();
    check_a("t2_idle", S_IDLE, 0, 0, 1, 1);

    // Abort coinciding with the final increment: abort wins.
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick(); tick();
    check_a("t3_pre", S_RUN, 1, 0, 0, 3);
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    check_a("t3_error", S_ERR, 0, 0, 1, 3);
    tick();

    // start during RUN ignored; start in COMPLETE restarts immediately.
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    check_a("t4_start_in_run", S_RUN, 1, 0, 0, 2);
    tick();
    tick();
    check_a("t4_complete", S_COMP, 0, 1, 0, 4);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check_a("t4_restart", S_RUN, 1, 0, 0, 0);

    // Reset mid-job with start and abort held: everything back to reset.
    tick(); tick();
    check_a("t5_pre", S_RUN, 1, 0, 0, 2);
    rst = 1'b1; start_a = 1'b1; abort_a = 1'b1; tick();
    check_a("t5_reset", S_IDLE, 0, 0, 0, 0);
    tick();
    check_a("t5_reset_hold", S_IDLE, 0, 0, 0, 0);
    rst = 1'b0; start_a = 1'b0; abort_a = 1'b0; tick();
    check_a("t5_after", S_IDLE, 0, 0, 0, 0);

    // Polling master on the 16-cycle instance, three jobs back-to-back.
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int job = 0; job < 3; job++) begin
      k = 0;
      while (!(!busy_b && done_b) && k < 40) begin
        tick();
        k++;
      end
      check($sformatf("t6_job%0d_len", job), 32'(k), 32'd16);
      check($sformatf("t6_job%0d_prog", job), 32'(progress_b), 32'd16);
      check($sformatf("t6_job%0d_err", job), 32'(error_b), 32'd0);
      if (job < 2) begin
        start_b = 1'b1; tick(); start_b = 1'b0;
        check($sformatf("t6_job%0d_next_state", job), 32'(state_b), 32'(S_RUN));
        check($sformatf("t6_job%0d_next_done", job), 32'(done_b), 32'd0);
      end else begin
        tick();
        check("t6_final_state", 32'(state_b), 32'(S_IDLE));
        check("t6_final_done", 32'(done_b), 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
